// File: rtl/tff_toggle_sequencer_pkg.sv
// Shared types and default widths for the toggle sequencer slice.
package tff_toggle_sequencer_pkg;

    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_PER_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : tff_toggle_sequencer_pkg

// File: rtl/tff_toggle_sequencer_if.sv
// Control/feedback bundle between a controller and the toggle sequencer.
interface tff_toggle_sequencer_if
    import tff_toggle_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned PER_W = DEF_PER_W
);
    logic             start;
    logic [PER_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic             q_fb;
    logic             t;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] pulses_sent;

    modport master (
        output start, period, count, q_fb,
        input  t, busy, done, err, pulses_sent
    );

    modport slave (
        input  start, period, count, q_fb,
        output t, busy, done, err, pulses_sent
    );
endinterface : tff_toggle_sequencer_if

// File: rtl/tff_toggle_sequencer_period_divider.sv
// Reloadable down-counter that marks the cycles where the count sits at zero.
module tff_period_divider #(
    parameter int unsigned PER_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_i,
    input  logic [PER_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tick_c,
    output logic             tick_nxt_c
);
    logic [PER_W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; the counter parks at zero when not reloaded.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - PER_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c     = (cnt_q == '0);
    assign tick_nxt_c = (cnt_d == '0);
endmodule : tff_period_divider

// File: rtl/tff_toggle_sequencer.sv
// Issues a programmed number of T pulses at a programmed period and checks
// the flip-flop's Q feedback against the expected parity.
module tff_toggle_sequencer
    import tff_toggle_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned PER_W = DEF_PER_W
) (
    input  logic                   clk,
    input  logic                   clear,
    tff_toggle_sequencer_if.slave  bus
);
    state_e           state_q, state_d;
    logic [PER_W-1:0] eff_per_q, eff_per_d;
    logic [PER_W-1:0] eff_load;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] sent_inc;
    logic             exp_q, exp_d;
    logic             err_q, err_d;
    logic             t_q, t_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             div_load;
    logic             div_en;
    logic [PER_W-1:0] div_val;
    logic             div_tick_c;
    logic             div_tick_nxt_c;

    assign eff_load = (bus.period == '0) ? PER_W'(1) : bus.period;
    assign sent_inc = sent_q + CNT_W'(1);

    tff_period_divider #(.PER_W(PER_W)) u_div (
        .clk        (clk),
        .clear      (clear),
        .load_i     (div_load),
        .load_val_i (div_val),
        .en_i       (div_en),
        .tick_c     (div_tick_c),
        .tick_nxt_c (div_tick_nxt_c)
    );

    // Next-state, counters, parity tracking and registered-output decode.
    always_comb begin
        state_d   = state_q;
        eff_per_d = eff_per_q;
        count_d   = count_q;
        sent_d    = sent_q;
        exp_d     = exp_q;
        err_d     = err_q;
        div_load  = 1'b0;
        div_en    = 1'b0;
        div_val   = eff_per_q - PER_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    eff_per_d = eff_load;
                    count_d   = bus.count;
                    div_load  = 1'b1;
                    div_val   = eff_load - PER_W'(1);
                    sent_d    = '0;
                    err_d     = 1'b0;
                    exp_d     = bus.q_fb;
                    state_d   = (bus.count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.q_fb != exp_q) begin
                    err_d = 1'b1;
                end
                if (div_tick_c) begin
                    // Pulse edge: the flip-flop toggles here, so does exp_q.
                    div_load = 1'b1;
                    sent_d   = sent_inc;
                    exp_d    = ~exp_q;
                    if (sent_inc == count_q) begin
                        state_d = DONE;
                    end
                end else begin
                    div_en = 1'b1;
                end
            end
            DONE: begin
                if (bus.q_fb != exp_q) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        t_d    = (state_d == RUN) && div_tick_nxt_c;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            eff_per_q <= '0;
            count_q   <= '0;
            sent_q    <= '0;
            exp_q     <= 1'b0;
            err_q     <= 1'b0;
            t_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            eff_per_q <= eff_per_d;
            count_q   <= count_d;
            sent_q    <= sent_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            t_q       <= t_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.t           = t_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.pulses_sent = sent_q;
endmodule : tff_toggle_sequencer

// File: tb/tb_tff_toggle_sequencer.sv
// Self-checking bench: a behavioural toggle flip-flop closes the Q loop, and
// every cycle of every sequence is compared with a closed-form timeline.
module tb_tff_toggle_sequencer;
    import tff_toggle_sequencer_pkg::*;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PER_W = 8;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    tff_toggle_sequencer_if #(.CNT_W(CNT_W), .PER_W(PER_W)) bif ();

    tff_toggle_sequencer #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bif.slave)
    );

    // Downstream toggle flip-flop with asynchronous clear and set.
    logic ff_q;
    logic ff_clr_n = 1'b1;
    logic ff_set_n = 1'b1;
    always @(posedge clk or negedge ff_clr_n or negedge ff_set_n) begin
        if (!ff_clr_n)      ff_q <= 1'b0;
        else if (!ff_set_n) ff_q <= 1'b1;
        else if (bif.t)     ff_q <= ~ff_q;
    end
    assign bif.q_fb = ff_q;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic set_q(input bit v);
        @(negedge clk);
        if (v) ff_set_n = 1'b0;
        else   ff_clr_n = 1'b0;
        #1;
        ff_set_n = 1'b1;
        ff_clr_n = 1'b1;
    endtask

    // Returns at the negedge of the first cycle after the accepting edge.
    task automatic start_seq(input int unsigned per, input int unsigned cnt);
        @(negedge clk);
        bif.start  = 1'b1;
        bif.period = PER_W'(per);
        bif.count  = CNT_W'(cnt);
        @(negedge clk);
        bif.start  = 1'b0;
    endtask

    // Cycle k after acceptance: pulses at multiples of eff up to cnt*eff,
    // done one cycle later, pulses_sent counts pulses of earlier cycles.
    task automatic run_seq(input int unsigned per, input int unsigned cnt,
                           input int err_from, input int ffclr_at,
                           output bit fin_q, output logic [CNT_W-1:0] fin_sent);
        int unsigned eff;
        int unsigned total;
        eff   = (per == 0) ? 1 : per;
        total = cnt * eff;
        start_seq(per, cnt);
        for (int k = 1; k <= int'(total) + 1; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("t p%0d c%0d k%0d", per, cnt, k), 32'(bif.t),
                  32'((k <= int'(total)) && ((k % int'(eff)) == 0)));
            check($sformatf("busy p%0d c%0d k%0d", per, cnt, k), 32'(bif.busy), 32'(1));
            check($sformatf("done p%0d c%0d k%0d", per, cnt, k), 32'(bif.done),
                  32'(k == int'(total) + 1));
            check($sformatf("sent p%0d c%0d k%0d", per, cnt, k), 32'(bif.pulses_sent),
                  32'((k - 1) / int'(eff)));
            check($sformatf("err p%0d c%0d k%0d", per, cnt, k), 32'(bif.err),
                  32'((err_from != 0) && (k >= err_from)));
            if (k == ffclr_at) begin
                ff_clr_n = 1'b0;
                #1;
                ff_clr_n = 1'b1;
            end
        end
        fin_q    = ff_q;
        fin_sent = bif.pulses_sent;
    endtask

    task automatic check_idle(input string tag, input int unsigned sent_exp, input bit err_exp);
        @(negedge clk);
        check({tag, " idle t"},    32'(bif.t),           32'(0));
        check({tag, " idle busy"}, 32'(bif.busy),        32'(0));
        check({tag, " idle done"}, 32'(bif.done),        32'(0));
        check({tag, " idle sent"}, 32'(bif.pulses_sent), 32'(sent_exp));
        check({tag, " idle err"},  32'(bif.err),         32'(err_exp));
    endtask

    typedef struct {
        int unsigned per;
        int unsigned cnt;
        bit          q0;
        bit          exp_q;
        int unsigned exp_sent;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               vecs[5];
        bit                 fq;
        logic [CNT_W-1:0]   fs;
        bit                 q0;
        int unsigned        per;
        int unsigned        cnt;

        vecs[0] = '{per: 3, cnt: 4, q0: 1'b0, exp_q: 1'b0, exp_sent: 4};
        vecs[1] = '{per: 0, cnt: 5, q0: 1'b0, exp_q: 1'b1, exp_sent: 5};
        vecs[2] = '{per: 7, cnt: 0, q0: 1'b0, exp_q: 1'b0, exp_sent: 0};
        vecs[3] = '{per: 1, cnt: 3, q0: 1'b1, exp_q: 1'b0, exp_sent: 3};
        vecs[4] = '{per: 2, cnt: 1, q0: 1'b0, exp_q: 1'b1, exp_sent: 1};

        clear      = 1'b1;
        bif.start  = 1'b0;
        bif.period = '0;
        bif.count  = '0;
        #1 ff_clr_n = 1'b0;
        #1 ff_clr_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset t",    32'(bif.t),           32'(0));
        check("reset busy", 32'(bif.busy),        32'(0));
        check("reset done", 32'(bif.done),        32'(0));
        check("reset err",  32'(bif.err),         32'(0));
        check("reset sent", 32'(bif.pulses_sent), 32'(0));
        clear = 1'b0;

        // Table-driven directed sequences.
        for (int i = 0; i < 5; i++) begin
            set_q(vecs[i].q0);
            run_seq(vecs[i].per, vecs[i].cnt, 0, 0, fq, fs);
            check($sformatf("vec%0d final q", i), 32'(fq), 32'(vecs[i].exp_q));
            check($sformatf("vec%0d final sent", i), 32'(fs), 32'(vecs[i].exp_sent));
            check_idle($sformatf("vec%0d", i), vecs[i].exp_sent, 1'b0);
        end

        // Flip-flop cleared between 2nd and 3rd pulse; err sticks until restart.
        set_q(1'b1);
        run_seq(4, 4, 11, 10, fq, fs);
        check_idle("ffclr", 4, 1'b1);
        check_idle("ffclr hold", 4, 1'b1);
        run_seq(3, 2, 0, 0, fq, fs);
        check_idle("after ffclr", 2, 1'b0);

        // Repeat start while busy is ignored; clear aborts mid-sequence.
        set_q(1'b0);
        start_seq(2, 6);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("abort t k%0d", k), 32'(bif.t), 32'((k % 2) == 0));
            check($sformatf("abort sent k%0d", k), 32'(bif.pulses_sent), 32'((k - 1) / 2));
            if (k == 2) begin
                bif.start  = 1'b1;
                bif.period = PER_W'(1);
                bif.count  = CNT_W'(1);
            end
            if (k == 3) bif.start = 1'b0;
            if (k == 4) clear = 1'b1;
        end
        @(negedge clk);
        clear = 1'b0;
        check("abort t",    32'(bif.t),           32'(0));
        check("abort busy", 32'(bif.busy),        32'(0));
        check("abort done", 32'(bif.done),        32'(0));
        check("abort err",  32'(bif.err),         32'(0));
        check("abort sent", 32'(bif.pulses_sent), 32'(0));
        for (int k = 0; k < 6; k++) begin
            check_idle($sformatf("post-abort %0d", k), 0, 1'b0);
        end

        // Back-to-back: start the cycle after done, full-range count.
        set_q(1'b0);
        run_seq(2, 3, 0, 0, fq, fs);
        check("b2b first q", 32'(fq), 32'(1));
        run_seq(1, 255, 0, 0, fq, fs);
        check("b2b 255 q",    32'(fq), 32'(0));
        check("b2b 255 sent", 32'(fs), 32'(255));
        check_idle("b2b", 255, 1'b0);

        // Randomized sequences, sometimes chained without an idle gap.
        for (int i = 0; i < 25; i++) begin
            q0  = 1'($urandom_range(0, 1));
            per = $urandom_range(0, 5);
            cnt = $urandom_range(0, 12);
            set_q(q0);
            run_seq(per, cnt, 0, 0, fq, fs);
            check($sformatf("rnd%0d q", i), 32'(fq), 32'(q0 ^ cnt[0]));
            check($sformatf("rnd%0d sent", i), 32'(fs), 32'(cnt));
            if ($urandom_range(0, 1) == 1) begin
                check_idle($sformatf("rnd%0d", i), cnt, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_tff_toggle_sequencer
